// File: rtl/fp_mult_arbiter_pkg.sv
// fp_mult_arbiter_pkg: shared state encoding, FP constants and default sizes for the multiplier arbiter
package fp_mult_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;
  localparam int N_REQ_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] FP_ONE = 32'h3f800000;
  localparam logic [31:0] FP_ZERO = 32'h00000000;
endpackage

// File: rtl/fp_mult_arbiter_if.sv
// fp_mult_arbiter_if: requester-side and multiplier-side handshake bundle of the arbiter
interface fp_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 32
);
  logic [N_REQ*DATA_W-1:0] i_req_a;
  logic [N_REQ*DATA_W-1:0] i_req_b;
  logic [N_REQ-1:0] i_req_stb;
  logic [N_REQ-1:0] o_req_ack;
  logic [DATA_W-1:0] o_req_z;
  logic [N_REQ-1:0] o_req_z_stb;
  logic [N_REQ-1:0] i_req_z_ack;
  logic [DATA_W-1:0] o_unit_a;
  logic [DATA_W-1:0] o_unit_b;
  logic o_unit_ab_stb;
  logic i_unit_ab_ack;
  logic [DATA_W-1:0] i_unit_z;
  logic i_unit_z_stb;
  logic o_unit_z_ack;
  modport master (
    input  i_req_a, i_req_b, i_req_stb, i_req_z_ack, i_unit_ab_ack, i_unit_z, i_unit_z_stb,
    output o_req_ack, o_req_z, o_req_z_stb, o_unit_a, o_unit_b, o_unit_ab_stb, o_unit_z_ack
  );
  modport slave (
    output i_req_a, i_req_b, i_req_stb, i_req_z_ack, i_unit_ab_ack, i_unit_z, i_unit_z_stb,
    input  o_req_ack, o_req_z, o_req_z_stb, o_unit_a, o_unit_b, o_unit_ab_stb, o_unit_z_ack
  );
endinterface

// File: rtl/fp_mult_arbiter_rr_pick.sv
// fp_mult_arbiter_rr_pick: round-robin pick of the first request after last, wrapping mod N_REQ
module fp_mult_arbiter_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [ID_W-1:0]  id,
  output logic             valid
);
  int idx;
  // scan farthest offset first so the nearest requester after last overwrites
  always_comb begin
    id = '0;
    valid = 1'b0;
    idx = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % N_REQ;
      if (req[idx[ID_W-1:0]]) begin
        id = idx[ID_W-1:0];
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one stb/ack multiplier between N_REQ requesters, one transaction in flight
module fp_mult_arbiter
  import fp_mult_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic            i_CLK,
  input  logic            i_RSTN,
  fp_mult_arbiter_if.master bus,
  output logic            o_busy,
  output logic [ID_W-1:0] o_grant_id
);
  state_t state, state_nx;
  logic [DATA_W-1:0] a_q, b_q, z_q;
  logic [ID_W-1:0] id_q, last_q, pick_id;
  logic [N_REQ-1:0] ack_q;
  logic pick_vld, z_ack_q, grant, take_z, done;
  fp_mult_arbiter_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req(bus.i_req_stb),
    .last(last_q),
    .id(pick_id),
    .valid(pick_vld)
  );
  assign grant = state == IDLE && pick_vld;
  assign take_z = state == WAIT && bus.i_unit_z_stb;
  assign done = state == DELIVER && bus.i_req_z_ack[id_q];
  always_ff @(posedge i_CLK or negedge i_RSTN)
    if (!i_RSTN) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    bus.o_unit_ab_stb = state == ISSUE;
    bus.o_req_z_stb = state == DELIVER ? N_REQ'(1) << id_q : '0;
    o_busy = state != IDLE;
    case (state)
      IDLE:    state_nx = pick_vld ? ISSUE : IDLE;
      ISSUE:   state_nx = bus.i_unit_ab_ack ? WAIT : ISSUE;
      WAIT:    state_nx = bus.i_unit_z_stb ? DELIVER : WAIT;
      DELIVER: state_nx = bus.i_req_z_ack[id_q] ? IDLE : DELIVER;
      default: state_nx = IDLE;
    endcase
  end
  // reset pointer at N_REQ-1 so requester 0 wins the first arbitration
  always_ff @(posedge i_CLK or negedge i_RSTN)
    if (!i_RSTN) begin
      a_q <= '0;
      b_q <= '0;
      z_q <= '0;
      id_q <= '0;
      last_q <= ID_W'(N_REQ - 1);
      ack_q <= '0;
      z_ack_q <= 1'b0;
    end else begin
      ack_q <= grant ? N_REQ'(1) << pick_id : '0;
      z_ack_q <= take_z;
      if (grant) begin
        id_q <= pick_id;
        a_q <= bus.i_req_a[pick_id*DATA_W +: DATA_W];
        b_q <= bus.i_req_b[pick_id*DATA_W +: DATA_W];
      end
      if (take_z) z_q <= bus.i_unit_z;
      if (done) last_q <= id_q;
    end
  assign bus.o_req_ack = ack_q;
  assign bus.o_req_z = z_q;
  assign bus.o_unit_a = a_q;
  assign bus.o_unit_b = b_q;
  assign bus.o_unit_z_ack = z_ack_q;
  assign o_grant_id = id_q;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: directed scoreboard bench with a behavioural stb/ack multiplier on the unit side
module tb_fp_mult_arbiter;
  import fp_mult_arbiter_pkg::*;
  localparam int N = 4;
  localparam int W = 32;
  typedef struct {
    int id;
    logic [31:0] z;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [1:0] gid;
  fp_mult_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();
  fp_mult_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .i_CLK(clk),
    .i_RSTN(rst_n),
    .bus(bus),
    .o_busy(busy),
    .o_grant_id(gid)
  );
  always #5 clk = ~clk;
  exp_t sb[$];
  int grants[$];
  int total = 0;
  int bad = 0;
  int hold[N];
  int last_gnt = -1;
  int unit_lat_force = 0;
  logic [N-1:0] ack_prev, stray;
  logic [31:0] ua, ub;
  int ucnt;
  logic ubusy;

  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    logic [47:0] m;
    logic [8:0] e;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 9'(a[30:23]) + 9'(b[30:23]) - 9'd127;
    if (m[47]) begin
      e = e + 9'd1;
      return {a[31] ^ b[31], e[7:0], m[46:24]};
    end
    return {a[31] ^ b[31], e[7:0], m[45:23]};
  endfunction

  // behavioural shared multiplier: ack operands, random latency, hold z until acked
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.i_unit_ab_ack <= 1'b0;
      bus.i_unit_z_stb <= 1'b0;
      bus.i_unit_z <= '0;
      ubusy <= 1'b0;
      ucnt <= 0;
      ua <= '0;
      ub <= '0;
    end else if (bus.i_unit_ab_ack) begin
      bus.i_unit_ab_ack <= 1'b0;
      ubusy <= 1'b1;
      ucnt <= unit_lat_force > 0 ? unit_lat_force : int'($urandom_range(3, 1));
    end else if (!ubusy && !bus.i_unit_z_stb && bus.o_unit_ab_stb) begin
      bus.i_unit_ab_ack <= 1'b1;
      ua <= bus.o_unit_a;
      ub <= bus.o_unit_b;
    end else if (ubusy) begin
      if (ucnt > 1) ucnt <= ucnt - 1;
      else begin
        ubusy <= 1'b0;
        bus.i_unit_z_stb <= 1'b1;
        bus.i_unit_z <= fmul(ua, ub);
      end
    end else if (bus.i_unit_z_stb && bus.o_unit_z_ack) bus.i_unit_z_stb <= 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(int k, logic [31:0] a, logic [31:0] b, logic [31:0] z);
    bus.i_req_a[k*W +: W] = a;
    bus.i_req_b[k*W +: W] = b;
    bus.i_req_stb[k] = 1'b1;
    sb.push_back(exp_t'{id: k, z: z});
  endtask

  // one clock of requester behaviour: retire acked stb, log grants, accept/score results
  task automatic step();
    int k;
    int idx;
    @(posedge clk);
    #1;
    for (int j = 0; j < N; j++) if (ack_prev[j]) bus.i_req_stb[j] = 1'b0;
    ack_prev = bus.o_req_ack;
    bus.i_req_z_ack = stray;
    for (int j = 0; j < N; j++)
      if (bus.o_req_ack[j]) begin
        grants.push_back(j);
        last_gnt = j;
        chk("ack_only_to_live_req", 32'(bus.i_req_stb[j]), 1);
        chk("grant_id", 32'(gid), j);
      end
    if (|bus.o_req_ack) chk("ack_onehot", 32'($onehot(bus.o_req_ack)), 1);
    if (|bus.o_req_z_stb) begin
      k = 0;
      for (int j = N - 1; j >= 0; j--) if (bus.o_req_z_stb[j]) k = j;
      chk("zstb_only_owner", 32'(bus.o_req_z_stb), 32'(1) << k);
      chk("zstb_owner", k, last_gnt);
      chk("no_issue_in_deliver", 32'(bus.o_unit_ab_stb), 0);
      if (hold[k] > 0) begin
        hold[k]--;
        chk("no_grant_while_held", 32'(bus.o_req_ack), 0);
      end else begin
        bus.i_req_z_ack[k] = 1'b1;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].id == k) idx = i;
        if (idx < 0) chk("z_unexpected_owner", k, 32'hffffffff);
        else begin
          chk("z_value", bus.o_req_z, sb[idx].z);
          sb.delete(idx);
        end
      end
    end
  endtask

  task automatic drain(int max);
    int n;
    logic fin;
    n = 0;
    do begin
      step();
      n++;
      fin = !busy && bus.i_req_stb == '0 && sb.size() == 0;
    end while (!fin && n < max);
    chk("drain_in_budget", 32'(fin), 1);
  endtask

  task automatic reset_outputs(string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ack"}, 32'(bus.o_req_ack), 0);
    chk({tag, "_zstb"}, 32'(bus.o_req_z_stb), 0);
    chk({tag, "_ab_stb"}, 32'(bus.o_unit_ab_stb), 0);
    chk({tag, "_z_ack"}, 32'(bus.o_unit_z_ack), 0);
    chk({tag, "_z"}, bus.o_req_z, FP_ZERO);
    chk({tag, "_unit_a"}, bus.o_unit_a, FP_ZERO);
    chk({tag, "_gid"}, 32'(gid), 0);
  endtask

  initial begin
    int g0[4] = '{0, 1, 2, 3};
    int g3[2] = '{3, 0};
    int g4[3] = '{1, 2, 3};
    logic hit;
    bus.i_req_a = '0;
    bus.i_req_b = '0;
    bus.i_req_stb = '0;
    bus.i_req_z_ack = '0;
    stray = '0;
    ack_prev = '0;
    for (int i = 0; i < N; i++) hold[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_outputs("rst");
    rst_n = 1'b1;
    // all four at once: reset pointer gives 0,1,2,3
    req(0, FP_ONE, 32'hc0000000, 32'hc0000000);
    req(1, 32'h40000000, 32'h40000000, 32'h40800000);
    req(2, 32'h40400000, 32'h40400000, 32'h41100000);
    req(3, 32'h3fc00000, 32'h40800000, 32'h40c00000);
    drain(200);
    chk("all4_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("all4_order", grants[i], g0[i]);
    // single request, ack one cycle later
    grants.delete();
    req(1, 32'h40000000, 32'h40400000, 32'h40c00000);
    step();
    chk("req1_ack_latency", 32'(bus.o_req_ack), 32'b0010);
    drain(100);
    // pointer at 2: req3 wins over req0
    req(2, FP_ONE, FP_ONE, FP_ONE);
    drain(100);
    grants.delete();
    req(0, 32'h40000000, 32'h3f000000, FP_ONE);
    req(3, 32'h40800000, 32'h40800000, 32'h41800000);
    drain(100);
    chk("rr_count", grants.size(), 2);
    for (int i = 0; i < 2 && i < grants.size(); i++) chk("rr_order", grants[i], g3[i]);
    // owner stalls result acceptance for 5 cycles
    grants.delete();
    hold[1] = 5;
    req(1, 32'h40400000, 32'h3fc00000, 32'h40900000);
    req(2, 32'hc0000000, 32'hc0000000, 32'h40800000);
    req(3, FP_ONE, 32'h41200000, 32'h41200000);
    drain(200);
    chk("hold_consumed", hold[1], 0);
    chk("hold_count", grants.size(), 3);
    for (int i = 0; i < 3 && i < grants.size(); i++) chk("hold_order", grants[i], g4[i]);
    // async reset while the unit is computing
    unit_lat_force = 20;
    req(0, 32'h40000000, 32'h40400000, 32'h40c00000);
    hit = 1'b0;
    for (int i = 0; i < 15 && !hit; i++) begin
      step();
      hit = busy && !bus.o_unit_ab_stb && bus.o_req_z_stb == '0;
    end
    chk("reached_wait", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    reset_outputs("midrst");
    sb.delete();
    bus.i_req_stb = '0;
    bus.i_req_z_ack = '0;
    ack_prev = '0;
    unit_lat_force = 0;
    #3;
    rst_n = 1'b1;
    grants.delete();
    req(2, 32'h40000000, 32'h40000000, 32'h40800000);
    req(0, FP_ONE, FP_ONE, FP_ONE);
    req(1, 32'h40000000, 32'h3f000000, FP_ONE);
    drain(200);
    chk("postrst_count", grants.size(), 3);
    for (int i = 0; i < 3 && i < grants.size(); i++) chk("postrst_order", grants[i], g0[i]);
    // stray result acks and a request pulse dropped before any ack
    grants.delete();
    hold[3] = 4;
    stray = 4'b0111;
    req(3, 32'h40a00000, 32'h40000000, 32'h41200000);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      hit = bus.o_req_z_stb != '0;
    end
    chk("reached_deliver", 32'(hit), 1);
    bus.i_req_stb[1] = 1'b1;
    step();
    bus.i_req_stb[1] = 1'b0;
    drain(100);
    stray = '0;
    chk("stray_grant_count", grants.size(), 1);
    if (grants.size() > 0) chk("stray_grant_id", grants[0], 3);
    step();
    chk("idle_after_pulse", 32'(busy), 0);
    chk("final_gid", 32'(gid), 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
